// File: rtl/turn_controller_if.sv
// Move-request bus between the board keys / grid register and turn_controller.
// The slave side is the controller; the master side is the board and datapath.
interface turn_controller_if;
    logic        confirm_n;
    logic [3:0]  address;
    logic [17:0] grid;
    logic        end_signal;
    logic        ld;
    logic [3:0]  wr_addr;
    logic [1:0]  value;
    logic [1:0]  player;
    logic        reject;
    logic        timeout;
    logic [3:0]  move_count;
    logic        done;

    modport slave (
        input  confirm_n, address, grid, end_signal,
        output ld, wr_addr, value, player, reject, timeout, move_count, done
    );

    modport master (
        output confirm_n, address, grid, end_signal,
        input  ld, wr_addr, value, player, reject, timeout, move_count, done
    );
endinterface

// File: rtl/turn_controller.sv
// Tic-tac-toe turn sequencer: debounced confirm press -> cell validation -> one
// write strobe per legal move, player alternation and inactivity forfeit.
module turn_controller #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd500_000_000,
    parameter int          TIMER_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    turn_controller_if.slave  bus
);
    localparam logic [2:0] S_WAIT    = 3'd0;
    localparam logic [2:0] S_CHECK   = 3'd1;
    localparam logic [2:0] S_WRITE   = 3'd2;
    localparam logic [2:0] S_REJECT  = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    localparam logic               TO_EN   = (TIMEOUT_CYCLES != 32'd0);
    localparam logic [TIMER_W-1:0] TO_LAST = TIMER_W'(TIMEOUT_CYCLES - 32'd1);

    logic [2:0]         r_state;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_sync_prev;
    logic [3:0]         r_req_addr;
    logic [1:0]         r_player;
    logic [3:0]         r_move_count;
    logic [TIMER_W-1:0] r_timer;
    logic               r_timeout;

    logic               w_press_evt;
    logic               w_expire;
    logic [1:0]         w_cell;
    logic               w_illegal;
    logic [2:0]         w_next_state;

    assign w_press_evt = r_sync_prev & ~r_sync2;

    // A press on the expiry cycle, or game over, suppresses the forfeit.
    assign w_expire = TO_EN && (r_state == S_WAIT) && (r_timer == TO_LAST)
                      && !w_press_evt && !bus.end_signal;

    always_comb begin
        w_cell = 2'b00;
        case (r_req_addr)
            4'd0:    w_cell = bus.grid[17:16];
            4'd1:    w_cell = bus.grid[15:14];
            4'd2:    w_cell = bus.grid[13:12];
            4'd3:    w_cell = bus.grid[11:10];
            4'd4:    w_cell = bus.grid[9:8];
            4'd5:    w_cell = bus.grid[7:6];
            4'd6:    w_cell = bus.grid[5:4];
            4'd7:    w_cell = bus.grid[3:2];
            4'd8:    w_cell = bus.grid[1:0];
            default: w_cell = 2'b00;
        endcase
    end

    assign w_illegal = (r_req_addr > 4'd8) || (w_cell != 2'b00);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_WAIT: begin
                if (bus.end_signal)
                    w_next_state = S_DONE;
                else if (w_press_evt)
                    w_next_state = S_CHECK;
            end
            S_CHECK:   w_next_state = w_illegal ? S_REJECT : S_WRITE;
            S_WRITE:   w_next_state = S_RELEASE;
            S_REJECT:  w_next_state = S_RELEASE;
            S_RELEASE: begin
                if (bus.end_signal)
                    w_next_state = S_DONE;
                else if (r_sync2)
                    w_next_state = S_WAIT;
            end
            S_DONE:    w_next_state = S_DONE;
            default:   w_next_state = S_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_WAIT;
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_sync_prev  <= 1'b1;
            r_req_addr   <= 4'd0;
            r_player     <= 2'd1;
            r_move_count <= 4'd0;
            r_timer      <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_sync1     <= bus.confirm_n;
            r_sync2     <= r_sync1;
            r_sync_prev <= r_sync2;
            r_state     <= w_next_state;
            r_timeout   <= w_expire;

            if ((r_state == S_WAIT) && (w_next_state == S_CHECK))
                r_req_addr <= bus.address;

            if ((r_state == S_WRITE) || w_expire)
                r_player <= (r_player == 2'd1) ? 2'd2 : 2'd1;

            if ((r_state == S_WRITE) && (r_move_count < 4'd9))
                r_move_count <= r_move_count + 4'd1;

            // Timer only runs while idling in WAIT; it reads 0 on every WAIT entry.
            if (TO_EN && (r_state == S_WAIT) && (w_next_state == S_WAIT) && !w_expire)
                r_timer <= r_timer + TIMER_W'(1);
            else
                r_timer <= '0;
        end
    end

    assign bus.ld         = (r_state == S_WRITE);
    assign bus.reject     = (r_state == S_REJECT);
    assign bus.done       = (r_state == S_DONE);
    assign bus.timeout    = r_timeout;
    assign bus.wr_addr    = r_req_addr;
    assign bus.value      = r_player;
    assign bus.player     = r_player;
    assign bus.move_count = r_move_count;
endmodule

// File: tb/tb_turn_controller.sv
// Bench for turn_controller: vector table of single moves, randomized games
// against a board model, and directed multi-cycle corner sequences.
module tb_turn_controller;
    logic clk;
    logic reset;
    int   n_total;
    int   n_bad;

    turn_controller_if tif();

    turn_controller #(.TIMEOUT_CYCLES(32'd20), .TIMER_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (tif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    typedef struct {
        logic [3:0]  addr;
        logic [17:0] grid;
        logic        exp_ld;
        logic        exp_rej;
    } vec_t;

    vec_t vecs[8];

    int mboard[9];
    int mplayer;
    int mcount;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [17:0] pack_board();
        logic [17:0] g;
        g = '0;
        for (int a = 0; a < 9; a++)
            g[17-2*a -: 2] = 2'(mboard[a]);
        return g;
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 9; a++) mboard[a] = 0;
        mplayer = 1;
        mcount  = 0;
    endtask

    task automatic do_reset();
        tif.confirm_n  = 1'b1;
        tif.end_signal = 1'b0;
        tif.address    = 4'd0;
        tif.grid       = '0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    // Press, wait (bounded) for ld/reject, release, and settle back in WAIT.
    task automatic do_press(input logic [3:0] addr, output logic got_ld, output logic got_rej,
                            output int lat, output logic [3:0] wa, output logic [1:0] val);
        got_ld = 0; got_rej = 0; lat = 0; wa = 0; val = 0;
        @(posedge clk);
        #1;
        tif.address   = addr;
        tif.confirm_n = 1'b0;
        for (int n = 1; n <= 12; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 3) tif.address = 4'($urandom);
            if (tif.ld || tif.reject) begin
                got_ld = tif.ld; got_rej = tif.reject; lat = n;
                wa = tif.wr_addr; val = tif.value;
                break;
            end
        end
        if (lat != 0) begin
            @(negedge clk);
            chk("pulse_width", {30'd0, tif.ld, tif.reject}, 0);
        end
        tif.confirm_n = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic play(input logic [3:0] addr);
        logic gl, gr;
        int lat;
        logic [3:0] wa;
        logic [1:0] val;
        logic legal;
        legal = (addr <= 4'd8) && (mboard[addr] == 0);
        do_press(addr, gl, gr, lat, wa, val);
        chk("latency", lat, 4);
        chk("ld", gl, legal);
        chk("reject", gr, !legal);
        if (legal) begin
            chk("wr_addr", wa, addr);
            chk("value", val, mplayer);
            mboard[addr] = mplayer;
            mplayer = 3 - mplayer;
            if (mcount < 9) mcount++;
            tif.grid = pack_board();
        end
        chk("player", tif.player, mplayer);
        chk("move_count", tif.move_count, mcount);
    endtask

    initial begin
        logic gl, gr;
        int lat, first, cnt_ld, cnt_rej, cnt_to;
        logic [3:0] wa;
        logic [1:0] val;

        n_total = 0;
        n_bad   = 0;
        vecs[0] = '{4'd4,  18'h00000, 1'b1, 1'b0};
        vecs[1] = '{4'd0,  18'h10000, 1'b0, 1'b1};
        vecs[2] = '{4'd8,  18'h00002, 1'b0, 1'b1};
        vecs[3] = '{4'd8,  18'h3FFFC, 1'b1, 1'b0};
        vecs[4] = '{4'd9,  18'h00000, 1'b0, 1'b1};
        vecs[5] = '{4'd15, 18'h00000, 1'b0, 1'b1};
        vecs[6] = '{4'd3,  18'h01200, 1'b1, 1'b0};
        vecs[7] = '{4'd2,  18'h01200, 1'b0, 1'b1};

        // Reset values
        do_reset();
        @(negedge clk);
        chk("rst_ld", tif.ld, 0);
        chk("rst_reject", tif.reject, 0);
        chk("rst_timeout", tif.timeout, 0);
        chk("rst_done", tif.done, 0);
        chk("rst_player", tif.player, 1);
        chk("rst_move_count", tif.move_count, 0);
        chk("rst_wr_addr", tif.wr_addr, 0);
        chk("rst_value", tif.value, 1);

        // Vector table: one move from reset against a fixed grid
        for (int i = 0; i < 8; i++) begin
            do_reset();
            tif.grid = vecs[i].grid;
            do_press(vecs[i].addr, gl, gr, lat, wa, val);
            chk("vec_latency", lat, 4);
            chk("vec_ld", gl, vecs[i].exp_ld);
            chk("vec_reject", gr, vecs[i].exp_rej);
            if (vecs[i].exp_ld) begin
                chk("vec_wr_addr", wa, vecs[i].addr);
                chk("vec_value", val, 1);
            end
            chk("vec_player", tif.player, vecs[i].exp_ld ? 2 : 1);
            chk("vec_move_count", tif.move_count, vecs[i].exp_ld ? 1 : 0);
        end

        // Occupied and out-of-range with player two to move
        do_reset();
        model_reset();
        play(4'd0);
        mboard[4] = 1;
        tif.grid = pack_board();
        play(4'd4);
        play(4'd12);

        // Randomized games against the board model
        for (int g = 0; g < 2; g++) begin
            do_reset();
            model_reset();
            for (int i = 0; i < 30; i++) begin
                repeat ($urandom_range(0, 3)) @(posedge clk);
                play(4'($urandom_range(0, 15)));
            end
        end

        // Held key: exactly one move, then release and a second press works
        do_reset();
        model_reset();
        tif.address   = 4'd1;
        tif.confirm_n = 1'b0;
        cnt_ld = 0; cnt_rej = 0; cnt_to = 0;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            if (tif.ld) cnt_ld++;
            if (tif.reject) cnt_rej++;
            if (tif.timeout) cnt_to++;
        end
        chk("held_ld_count", cnt_ld, 1);
        chk("held_reject_count", cnt_rej, 0);
        chk("held_timeout_count", cnt_to, 0);
        tif.confirm_n = 1'b1;
        mboard[1] = 1; mplayer = 2; mcount = 1;
        tif.grid = pack_board();
        repeat (5) @(posedge clk);
        play(4'd5);

        // Timeout: pulses every 20 idle WAIT cycles, alternating the player
        do_reset();
        first = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); @(negedge clk);
            if (tif.timeout) begin first = n; break; end
        end
        chk("timeout_first", first, 20);
        chk("timeout_player1", tif.player, 2);
        first = 0;
        for (int n = 1; n <= 60; n++) begin
            @(posedge clk); @(negedge clk);
            if (tif.timeout) begin first = n; break; end
        end
        chk("timeout_second", first, 20);
        chk("timeout_player2", tif.player, 1);

        // Press detected on the expiry cycle wins over the forfeit
        do_reset();
        repeat (17) @(posedge clk);
        #1;
        tif.address   = 4'd6;
        tif.confirm_n = 1'b0;
        first = 0; cnt_to = 0; val = 0;
        for (int n = 1; n <= 8; n++) begin
            @(posedge clk); @(negedge clk);
            if (tif.ld && first == 0) begin first = n; val = tif.value; end
            if (tif.timeout) cnt_to++;
        end
        tif.confirm_n = 1'b1;
        chk("expiry_press_ld", first, 4);
        chk("expiry_press_value", val, 1);
        chk("expiry_press_timeout", cnt_to, 0);

        // End of game: frozen until reset
        do_reset();
        model_reset();
        play(4'd0); play(4'd3); play(4'd1); play(4'd4); play(4'd2);
        tif.end_signal = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("end_done", tif.done, 1);
        do_press(4'd6, gl, gr, lat, wa, val);
        chk("end_no_ld", gl, 0);
        chk("end_no_reject", gr, 0);
        tif.end_signal = 1'b0;
        cnt_to = 0;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (tif.timeout) cnt_to++;
        end
        chk("end_no_timeout", cnt_to, 0);
        chk("end_player_frozen", tif.player, 2);
        chk("end_count_frozen", tif.move_count, 5);
        chk("end_done_held", tif.done, 1);
        do_reset();
        @(negedge clk);
        chk("end_reset_done", tif.done, 0);

        // end_signal together with a press in WAIT: no move
        do_reset();
        tif.end_signal = 1'b1;
        tif.confirm_n  = 1'b0;
        cnt_ld = 0; cnt_rej = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (tif.ld) cnt_ld++;
            if (tif.reject) cnt_rej++;
        end
        chk("end_press_ld", cnt_ld, 0);
        chk("end_press_reject", cnt_rej, 0);
        chk("end_press_done", tif.done, 1);

        // Reset asserted during the WRITE cycle
        do_reset();
        model_reset();
        tif.address   = 4'd7;
        tif.confirm_n = 1'b0;
        first = 0;
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            if (tif.ld) begin first = n; break; end
        end
        chk("midmove_reached_write", first != 0, 1);
        reset = 1'b1;
        tif.confirm_n = 1'b1;
        @(posedge clk); @(negedge clk);
        chk("midmove_ld", tif.ld, 0);
        chk("midmove_player", tif.player, 1);
        chk("midmove_count", tif.move_count, 0);
        chk("midmove_done", tif.done, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        tif.grid = '0;
        play(4'd7);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/turn_controller.md
# turn_controller

Sequencing controller for the tic-tac-toe grid datapath. It converts the raw, active-low confirm key into single move requests and validates each requested cell against the current grid. It issues exactly one write strobe per legal move, alternates players, and forfeits a turn on inactivity. It replaces the free-running two-player load FSM, sits between the board keys and the grid register, and consumes the win/draw end signal.

## Interface

Parameters:
- TIMEOUT_CYCLES, default 32'd500_000_000: idle cycles before the current player forfeits the turn. 0 disables the timeout.
- TIMER_W, default 32: width of the timeout counter. It must hold TIMEOUT_CYCLES-1.

Ports:
- clk  in  1  system clock. One clock domain; all state changes on posedge clk.
- reset  in  1  synchronous, active-high reset.
- confirm_n  in  1  raw confirm key, active-low, asynchronous to clk.
- address  in  4  requested cell, 0..8, row-major.
- grid  in  18  current board. Cell a is grid[17-2a:16-2a]. 0 = empty, 1 = player one, 2 = player two.
- end_signal  in  1  game over (win or draw), from win detection.
- ld  out  1  one-cycle write strobe to the grid datapath.
- wr_addr  out  4  cell to write; valid while ld=1.
- value  out  2  mark to write (1 or 2); valid while ld=1.
- player  out  2  player whose turn it is (1 or 2).
- reject  out  1  one-cycle pulse: illegal move request.
- timeout  out  1  one-cycle pulse: turn forfeited.
- move_count  out  4  legal moves accepted since reset (0..9).
- done  out  1  game over; the controller is frozen.

## Operation

- Input conditioning:
  - confirm_n passes through a 2-flop synchronizer, then an edge detector.
  - press_evt = synced value was 1 last cycle and is 0 this cycle.
  - Synchronizer flops reset to 1.
- States:
  - WAIT: idle, waiting for a press.
  - CHECK: validate the captured request.
  - WRITE: ld=1.
  - REJECT: reject=1.
  - RELEASE: wait for the key to be released.
  - DONE: game over.
- Transitions:
  - WAIT, end_signal=1 -> DONE. This has priority over everything else.
  - WAIT, press_evt -> CHECK. Latch address into req_addr.
  - WAIT, timer reaches TIMEOUT_CYCLES-1 with no press_evt -> stay in WAIT. Toggle player, pulse timeout, clear timer.
  - CHECK -> REJECT if req_addr > 8 or the grid cell at req_addr != 0. Otherwise -> WRITE.
  - WRITE -> RELEASE. player toggles 1<->2 and move_count increments, both on the edge leaving WRITE.
  - REJECT -> RELEASE. player is unchanged.
  - RELEASE -> WAIT once synced confirm_n = 1. Timer clears on entry to WAIT.
  - RELEASE with end_signal=1 -> DONE.
  - DONE -> DONE until reset. ld, reject and timeout stay 0. Presses are ignored.
- Outputs are Moore, decoded from state and registers:
  - ld=1 only in WRITE.
  - value = player.
  - wr_addr = req_addr.
  - done=1 only in DONE.
- The timer counts only in WAIT. It holds 0 in every other state.
- Changes to address after capture have no effect on the move in flight.
- grid is sampled combinationally in CHECK. The datapath write lands one cycle after WRITE, before the next CHECK can occur.

## Timing

- Reset values:
  - state = WAIT
  - player = 1
  - move_count = 0
  - timer = 0
  - ld, reject, timeout, done = 0
  - wr_addr = 0, value = 1
- Latency: press_evt in cycle N -> CHECK at N+1 -> ld (or reject) high at N+2, for exactly one cycle.
- A key held low produces exactly one move. A second move requires release, then a new press.
- Simultaneous press_evt and timeout expiry in WAIT: the press wins. No timeout pulse, player unchanged.
- Simultaneous end_signal and press_evt in WAIT: go to DONE. No move is issued.
- Reset asserted in any state, including the WRITE cycle: the next cycle is at reset values. The grid datapath shares this reset.
- move_count saturates at 9. With no win, the draw sets end_signal after the 9th write.

## Test plan

- Legal move: reset, address=4, press. Required: ld=1 for 1 cycle exactly 2 cycles after press_evt, with wr_addr=4, value=1. Then player=2, move_count=1.
- Occupied or out-of-range cell: grid cell 4 = 1, player=2, press with address=4; then press with address=12. Required: reject pulses each time, ld stays 0, player stays 2, move_count is unchanged.
- Held key: confirm_n low for 1000 cycles. Required: exactly one ld pulse. No further action until release and a new press.
- Timeout: TIMEOUT_CYCLES=20, no press after reset. Required: timeout pulses at WAIT cycle 20, player=2. A second pulse 20 cycles later, player=1. A press on the expiry cycle gives ld and no timeout pulse.
- End of game: drive end_signal=1 after a winning write. Required: done=1. Later presses give no ld or reject, and player and move_count are frozen until reset.
- Reset mid-move: assert reset in the WRITE cycle. Required: the next cycle has ld=0, player=1, move_count=0, state=WAIT.
